// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer.
// Registered in_ready, synchronous flush to bubble, saturating stall counter.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W       = 65,
    parameter logic [DATA_W-1:0] BUBBLE_VALUE = DATA_W'('h13),
    parameter int unsigned       CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [DATA_W-1:0] m_q, s_q, m_n, s_n;
    logic              m_v, s_v, m_v_n, s_v_n;
    logic              rdy_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              in_fire, out_fire;

    assign in_ready  = rdy_q;
    assign out_valid = m_v;
    assign out_data  = m_v ? m_q : BUBBLE_VALUE;
    assign stall_cnt = cnt_q;

    assign in_fire  = in_valid & rdy_q;
    assign out_fire = m_v & out_ready;

    always_comb begin
        m_n   = m_q;
        s_n   = s_q;
        m_v_n = m_v;
        s_v_n = s_v;
        if (flush) begin
            m_n   = BUBBLE_VALUE;
            s_n   = BUBBLE_VALUE;
            m_v_n = 1'b0;
            s_v_n = 1'b0;
        end else if (out_fire || !m_v) begin
            if (s_v) begin
                // Skid entry is older than anything arriving now: promote it first.
                m_n   = s_q;
                m_v_n = 1'b1;
                if (in_fire) begin
                    s_n = in_data;
                end else begin
                    s_v_n = 1'b0;
                end
            end else begin
                m_n   = in_data;
                m_v_n = in_fire;
            end
        end else if (in_fire) begin
            s_n   = in_data;
            s_v_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q   <= BUBBLE_VALUE;
            s_q   <= BUBBLE_VALUE;
            m_v   <= 1'b0;
            s_v   <= 1'b0;
            rdy_q <= 1'b1;
        end else begin
            m_q   <= m_n;
            s_q   <= s_n;
            m_v   <= m_v_n;
            s_v   <= s_v_n;
            // Ready is its own flop so back-pressure never goes combinational upstream.
            rdy_q <= ~s_v_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (m_v && !out_ready && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus random traffic
// against a queue-based reference model of a 2-deep FIFO stage.
module tb_pipe_stage_skid;

    localparam int unsigned       DATA_W  = 65;
    localparam int unsigned       CNT_W   = 4;
    localparam logic [DATA_W-1:0] BUBBLE  = DATA_W'('h13);
    localparam int unsigned       CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic [CNT_W-1:0]  stall_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [DATA_W-1:0] q[$];
    int unsigned       cnt_m = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W      (DATA_W),
        .BUBBLE_VALUE(BUBBLE),
        .CNT_W       (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .flush    (flush),
        .stall_cnt(stall_cnt)
    );

    task automatic check_outputs(input string tag);
        logic              e_rdy, e_vld;
        logic [DATA_W-1:0] e_dat;
        logic [CNT_W-1:0]  e_cnt;
        e_rdy = (q.size() < 2);
        e_vld = (q.size() > 0);
        e_dat = (q.size() > 0) ? q[0] : BUBBLE;
        e_cnt = CNT_W'(cnt_m);
        n_cmp++;
        assert (in_ready === e_rdy) else begin
            n_bad++;
            $error("FAIL %s in_ready got %0b want %0b", tag, in_ready, e_rdy);
        end
        n_cmp++;
        assert (out_valid === e_vld) else begin
            n_bad++;
            $error("FAIL %s out_valid got %0b want %0b", tag, out_valid, e_vld);
        end
        n_cmp++;
        assert (out_data === e_dat) else begin
            n_bad++;
            $error("FAIL %s out_data got %h want %h", tag, out_data, e_dat);
        end
        n_cmp++;
        assert (stall_cnt === e_cnt) else begin
            n_bad++;
            $error("FAIL %s stall_cnt got %0d want %0d", tag, stall_cnt, e_cnt);
        end
    endtask

    // Drive one cycle's inputs, check state-derived outputs, then advance the model.
    task automatic cycle(input string tag, input logic v, input logic [DATA_W-1:0] d,
                         input logic r, input logic f);
        logic ifire, ofire;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        check_outputs(tag);
        ifire = v && (q.size() < 2);
        ofire = r && (q.size() > 0);
        if (q.size() > 0 && !r && cnt_m < CNT_MAX) cnt_m++;
        if (f) begin
            q.delete();
        end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) q.push_back(d);
        end
        @(posedge clk);
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, 1'($urandom)};
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;
        cycle("idle", 1'b0, '0, 1'b1, 1'b0);
        cycle("idle", 1'b0, '0, 1'b1, 1'b0);

        // Streaming 1..4 with out_ready high
        for (int unsigned i = 1; i <= 4; i++) cycle("stream", 1'b1, DATA_W'(i), 1'b1, 1'b0);
        cycle("stream_drain", 1'b0, '0, 1'b1, 1'b0);
        cycle("stream_drain", 1'b0, '0, 1'b1, 1'b0);

        // Back-pressure: A, B, C with stall from second cycle
        cycle("bp_a", 1'b1, DATA_W'('hA), 1'b1, 1'b0);
        cycle("bp_b", 1'b1, DATA_W'('hB), 1'b0, 1'b0);
        for (int unsigned i = 0; i < 4; i++) cycle("bp_c_wait", 1'b1, DATA_W'('hC), 1'b0, 1'b0);
        for (int unsigned i = 0; i < 2; i++) cycle("bp_release", 1'b1, DATA_W'('hC), 1'b1, 1'b0);
        for (int unsigned i = 0; i < 3; i++) cycle("bp_drain", 1'b0, '0, 1'b1, 1'b0);

        // Flush while full with C offered
        cycle("fl_a", 1'b1, DATA_W'('h1A), 1'b0, 1'b0);
        cycle("fl_b", 1'b1, DATA_W'('h1B), 1'b0, 1'b0);
        cycle("fl_hit", 1'b1, DATA_W'('h1C), 1'b0, 1'b1);
        for (int unsigned i = 0; i < 3; i++) cycle("fl_after", 1'b0, '0, 1'b1, 1'b0);

        // Saturation: 20 stalled cycles with a held payload
        cycle("sat_load", 1'b1, DATA_W'('h55), 1'b0, 1'b0);
        for (int unsigned i = 0; i < 20; i++) cycle("sat", 1'b0, '0, 1'b0, 1'b0);
        cycle("sat_rel", 1'b0, '0, 1'b1, 1'b0);

        // Async reset mid-cycle while full
        cycle("ar_a", 1'b1, DATA_W'('h77), 1'b0, 1'b0);
        cycle("ar_b", 1'b1, DATA_W'('h78), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        q.delete();
        cnt_m = 0;
        check_outputs("async_rst");
        @(posedge clk);
        @(negedge clk);
        check_outputs("async_rst_hold");
        rst = 1'b0;
        for (int unsigned i = 1; i <= 3; i++) cycle("resume", 1'b1, DATA_W'(i + 'h90), 1'b1, 1'b0);
        cycle("resume_drain", 1'b0, '0, 1'b1, 1'b0);

        // Random traffic
        for (int unsigned i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom), rnd_data(), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 19) == 0));
        end
        for (int unsigned i = 0; i < 3; i++) cycle("rand_drain", 1'b0, '0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
